reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads 0, ignores writes and is never busy.
REQ-005 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to matching reads.
REQ-006 Port clock, input, 1, sole clock; all state updates on rising edge.
REQ-007 Port reset_n, input, 1, synchronous active-low reset.
REQ-008 Port RegWrite0 / RegWrite1, input, 1 each, write enable of write port 0 / 1.
REQ-009 Port WriteReg0 / WriteReg1, input, ADDR_W each, write address of port 0 / 1.
REQ-010 Port WriteData0 / WriteData1, input, DATA_W each, write data of port 0 / 1.
REQ-011 Port ReadReg, input, NUM_RD*ADDR_W, read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 Port ReadData, output, NUM_RD*DATA_W, read data; port i at bits [i*DATA_W +: DATA_W].
REQ-013 Port Issue, input, 1, marks IssueReg as having a pending write (scoreboard set).
REQ-014 Port IssueReg, input, ADDR_W, destination register being issued.
REQ-015 Port ReadBusy, output, NUM_RD, bit i high when read port i addresses a busy register.
REQ-016 Port NumBusy, output, ADDR_W+1, registered count of busy registers.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W flops; each write port SHALL update its addressed register on the rising edge when its enable is high and reset_n is high.
REQ-018 Both write ports enabled to the same address in one cycle: port 1 data SHALL be stored.
REQ-019 Reads SHALL be combinational: ReadData[i] = contents of ReadReg[i] in the same cycle.
REQ-020 With BYPASS=1 and reset_n high, a read whose address matches an enabled write SHALL return that write's data (port 1 over port 0); with BYPASS=0 it SHALL return the old contents.
REQ-021 With ZERO_REG=1, reads of address 0 SHALL return 0 regardless of writes or bypass, and writes to address 0 SHALL be discarded.
REQ-022 Scoreboard: one busy bit per register; Issue high SHALL set busy[IssueReg] on the next edge.
REQ-023 An enabled write on either port SHALL clear busy for its address on the next edge.
REQ-024 Issue and a write to the same address in one cycle: busy SHALL end set (new pending write wins).
REQ-025 With ZERO_REG=1, Issue to address 0 SHALL be ignored; busy[0] stays 0.
REQ-026 ReadBusy[i] SHALL equal busy[ReadReg[i]], except with BYPASS=1 it SHALL be 0 when a same-cycle enabled write matches ReadReg[i].
REQ-027 NumBusy SHALL be a register equal to the population count of the busy bits, updated in the same edge as the busy bits (no extra latency); range 0..DEPTH with no wrap.

Reset
REQ-028 While reset_n is low at a rising edge, all registers, all busy bits and NumBusy SHALL become 0.
REQ-029 Writes and Issue asserted in a reset cycle SHALL be discarded; bypass SHALL be suppressed while reset_n is low.
REQ-030 Reset asserted with pending writes mid-operation SHALL clear all busy bits; the first write after reset SHALL behave as an ordinary write.
REQ-031 After the reset edge, all ReadData outputs SHALL read 0 and ReadBusy SHALL be all zeros.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r5 via port 0; next cycle ReadReg[0]=5 -> ReadData[0]=0xDEADBEEF.
REQ-033 Same cycle: port 0 writes 0x1111 to r7, port 1 writes 0x2222 to r7, read r7 -> bypassed 0x2222 (BYPASS=1); next cycle r7 = 0x2222.
REQ-034 Write 0xFFFFFFFF to r0 with ZERO_REG=1, read r0 on all ports same and next cycle -> 0; Issue r0 -> NumBusy stays 0.
REQ-035 Issue r3, next cycle Issue r4 -> NumBusy 1 then 2, ReadBusy for r3 = 1; write r3 with Issue r3 same cycle -> r3 still busy, NumBusy 2; write r4 -> NumBusy 1.
REQ-036 Issue r9 and r10, write r9 = 0xABCD, then reset_n low one cycle with RegWrite0 high -> r9 reads 0, NumBusy 0, ReadBusy 0, write discarded.
REQ-037 NUM_RD=4, BYPASS=0: write r12 = 0x55 and read r12 on all four ports same cycle -> old value 0; next cycle all four -> 0x55.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file with two write ports, NUM_RD combinational read
// ports, optional hard-wired zero register, optional write-to-read forwarding
// and a per-register busy scoreboard with a registered busy count.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       RegWrite0,
    input  logic                       RegWrite1,
    input  logic [ADDR_W-1:0]          WriteReg0,
    input  logic [ADDR_W-1:0]          WriteReg1,
    input  logic [DATA_W-1:0]          WriteData0,
    input  logic [DATA_W-1:0]          WriteData1,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
    output logic [NUM_RD*DATA_W-1:0]   ReadData,
    input  logic                       Issue,
    input  logic [ADDR_W-1:0]          IssueReg,
    output logic [NUM_RD-1:0]          ReadBusy,
    output logic [ADDR_W:0]            NumBusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   num_busy_q;
    logic [ADDR_W:0]   busy_cnt;
    logic              wr0_en;
    logic              wr1_en;
    logic              fwd_en;

    // Writes to the zero register are dropped so it never holds data.
    assign wr0_en = RegWrite0 && !(ZERO_REG && (WriteReg0 == '0));
    assign wr1_en = RegWrite1 && !(ZERO_REG && (WriteReg1 == '0));
    assign fwd_en = BYPASS && reset_n;

    // Storage update; port 1 is applied last so it wins an address collision.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr0_en) regs_q[WriteReg0] <= WriteData0;
            if (wr1_en) regs_q[WriteReg1] <= WriteData1;
        end
    end

    // Scoreboard next state: writes retire, then a new issue re-marks busy.
    always_comb begin
        busy_d = busy_q;
        if (RegWrite0) busy_d[WriteReg0] = 1'b0;
        if (RegWrite1) busy_d[WriteReg1] = 1'b0;
        if (Issue) busy_d[IssueReg] = 1'b1;
        if (ZERO_REG) busy_d[0] = 1'b0;
    end

    // Popcount of the next busy vector so NumBusy tracks busy_q with no lag.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard and count registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q     <= '0;
            num_busy_q <= '0;
        end else begin
            busy_q     <= busy_d;
            num_busy_q <= busy_cnt;
        end
    end

    assign NumBusy = num_busy_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign addr = ReadReg[g*ADDR_W +: ADDR_W];

        // Read mux: forwarded write data (port 1 first), zero register overrides all.
        always_comb begin
            rd_data = regs_q[addr];
            rd_busy = busy_q[addr];
            if (fwd_en && RegWrite1 && (WriteReg1 == addr)) begin
                rd_data = WriteData1;
                rd_busy = 1'b0;
            end else if (fwd_en && RegWrite0 && (WriteReg0 == addr)) begin
                rd_data = WriteData0;
                rd_busy = 1'b0;
            end
            if (ZERO_REG && (addr == '0)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end

        assign ReadData[g*DATA_W +: DATA_W] = rd_data;
        assign ReadBusy[g]                  = rd_busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: instance A uses defaults (zero reg, bypass, 2 reads),
// instance B has no zero reg, no bypass and 4 read ports. Both share write and
// issue inputs and are checked every cycle against an array-based model.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NV    = 19;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            RegWrite0, RegWrite1;
    logic [AW-1:0]   WriteReg0, WriteReg1;
    logic [DW-1:0]   WriteData0, WriteData1;
    logic            Issue;
    logic [AW-1:0]   IssueReg;
    logic [2*AW-1:0] ra_a;
    logic [4*AW-1:0] ra_b;
    logic [2*DW-1:0] rd_a;
    logic [4*DW-1:0] rd_b;
    logic [1:0]      rb_a;
    logic [3:0]      rb_b;
    logic [AW:0]     nb_a, nb_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .RegWrite0(RegWrite0), .RegWrite1(RegWrite1),
        .WriteReg0(WriteReg0), .WriteReg1(WriteReg1),
        .WriteData0(WriteData0), .WriteData1(WriteData1),
        .ReadReg(ra_a), .ReadData(rd_a),
        .Issue(Issue), .IssueReg(IssueReg),
        .ReadBusy(rb_a), .NumBusy(nb_a)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .RegWrite0(RegWrite0), .RegWrite1(RegWrite1),
        .WriteReg0(WriteReg0), .WriteReg1(WriteReg1),
        .WriteData0(WriteData0), .WriteData1(WriteData1),
        .ReadReg(ra_b), .ReadData(rd_b),
        .Issue(Issue), .IssueReg(IssueReg),
        .ReadBusy(rb_b), .NumBusy(nb_b)
    );

    // Reference model; index 0 = instance A, index 1 = instance B.
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            m_busy [2][DEPTH];

    function automatic bit has_zero(int c);
        return c == 0;
    endfunction

    function automatic bit has_fwd(int c);
        return c == 0;
    endfunction

    function automatic bit wr_hits(int a);
        return (RegWrite0 && int'(WriteReg0) == a) || (RegWrite1 && int'(WriteReg1) == a);
    endfunction

    function automatic logic [DW-1:0] exp_data(int c, int a);
        if (has_zero(c) && a == 0) return '0;
        if (has_fwd(c) && reset_n) begin
            if (RegWrite1 && int'(WriteReg1) == a) return WriteData1;
            if (RegWrite0 && int'(WriteReg0) == a) return WriteData0;
        end
        return m_mem[c][a];
    endfunction

    function automatic bit exp_busy(int c, int a);
        if (has_zero(c) && a == 0) return 1'b0;
        if (has_fwd(c) && reset_n && wr_hits(a)) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic int exp_count(int c);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[c][i]);
        return n;
    endfunction

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[c][i]  = '0;
                    m_busy[c][i] = 1'b0;
                end
            end else begin
                if (RegWrite0 && !(has_zero(c) && WriteReg0 == 0)) m_mem[c][WriteReg0] = WriteData0;
                if (RegWrite1 && !(has_zero(c) && WriteReg1 == 0)) m_mem[c][WriteReg1] = WriteData1;
                if (RegWrite0) m_busy[c][WriteReg0] = 1'b0;
                if (RegWrite1) m_busy[c][WriteReg1] = 1'b0;
                if (Issue && !(has_zero(c) && IssueReg == 0)) m_busy[c][IssueReg] = 1'b1;
            end
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("A rdata%0d", i), 64'(rd_a[i*DW +: DW]),
                64'(exp_data(0, int'(ra_a[i*AW +: AW]))));
            chk($sformatf("A rbusy%0d", i), 64'(rb_a[i]), 64'(exp_busy(0, int'(ra_a[i*AW +: AW]))));
        end
        chk("A numbusy", 64'(nb_a), 64'(exp_count(0)));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("B rdata%0d", i), 64'(rd_b[i*DW +: DW]),
                64'(exp_data(1, int'(ra_b[i*AW +: AW]))));
            chk($sformatf("B rbusy%0d", i), 64'(rb_b[i]), 64'(exp_busy(1, int'(ra_b[i*AW +: AW]))));
        end
        chk("B numbusy", 64'(nb_b), 64'(exp_count(1)));
    endtask

    task automatic edge_update();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        RegWrite0 = 1'b0; RegWrite1 = 1'b0; Issue = 1'b0;
        WriteReg0 = '0; WriteReg1 = '0; IssueReg = '0;
        WriteData0 = '0; WriteData1 = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    // Directed vectors for instance A; expected values are pre-edge outputs.
    typedef struct {
        bit            rst_n;
        bit            we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        bit            we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        bit            iss;
        logic [AW-1:0] ir;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    erb;
        int            enb;
    } vec_t;

    vec_t tbl [NV];

    initial begin
        //         rst we0 wa0 wd0            we1 wa1 wd1       iss ir  ra0 ra1 e0             e1             erb    nb
        tbl[0]  = '{0, 1, 5,  32'h0000_0000, 0, 0,  32'h0,    1, 3,  5,  3,  32'h0,         32'h0,         2'b00, 0};
        tbl[1]  = '{1, 1, 5,  32'hDEAD_BEEF, 0, 0,  32'h0,    0, 0,  5,  0,  32'hDEAD_BEEF, 32'h0,         2'b00, 0};
        tbl[2]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  5,  5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0};
        tbl[3]  = '{1, 1, 7,  32'h0000_1111, 1, 7,  32'h2222, 0, 0,  7,  5,  32'h0000_2222, 32'hDEAD_BEEF, 2'b00, 0};
        tbl[4]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  7,  0,  32'h0000_2222, 32'h0,         2'b00, 0};
        tbl[5]  = '{1, 1, 0,  32'hFFFF_FFFF, 0, 0,  32'h0,    1, 0,  0,  0,  32'h0,         32'h0,         2'b00, 0};
        tbl[6]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 3,  0,  3,  32'h0,         32'h0,         2'b00, 0};
        tbl[7]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 4,  3,  4,  32'h0,         32'h0,         2'b01, 1};
        tbl[8]  = '{1, 1, 3,  32'h0000_0033, 0, 0,  32'h0,    1, 3,  3,  4,  32'h0000_0033, 32'h0,         2'b10, 2};
        tbl[9]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  3,  4,  32'h0000_0033, 32'h0,         2'b11, 2};
        tbl[10] = '{1, 0, 0,  32'h0,         1, 4,  32'h44,   0, 0,  4,  3,  32'h0000_0044, 32'h0000_0033, 2'b10, 2};
        tbl[11] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  4,  9,  32'h0000_0044, 32'h0,         2'b00, 1};
        tbl[12] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 9,  9,  10, 32'h0,         32'h0,         2'b00, 1};
        tbl[13] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    1, 10, 9,  10, 32'h0,         32'h0,         2'b01, 2};
        tbl[14] = '{1, 1, 9,  32'h0000_ABCD, 0, 0,  32'h0,    0, 0,  9,  10, 32'h0000_ABCD, 32'h0,         2'b10, 3};
        tbl[15] = '{0, 1, 9,  32'h0000_1234, 0, 0,  32'h0,    1, 5,  9,  10, 32'h0000_ABCD, 32'h0,         2'b10, 2};
        tbl[16] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  9,  10, 32'h0,         32'h0,         2'b00, 0};
        tbl[17] = '{1, 1, 9,  32'h0000_0077, 0, 0,  32'h0,    0, 0,  9,  5,  32'h0000_0077, 32'h0,         2'b00, 0};
        tbl[18] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,    0, 0,  9,  7,  32'h0000_0077, 32'h0,         2'b00, 0};

        // Power-on reset, unchecked: state is unknown before the first edge.
        reset_n = 1'b0;
        idle();
        ra_a = '0;
        ra_b = '0;
        #1;
        edge_update();
        edge_update();

        for (int k = 0; k < NV; k++) begin
            reset_n    = tbl[k].rst_n;
            RegWrite0  = tbl[k].we0;  WriteReg0 = tbl[k].wa0; WriteData0 = tbl[k].wd0;
            RegWrite1  = tbl[k].we1;  WriteReg1 = tbl[k].wa1; WriteData1 = tbl[k].wd1;
            Issue      = tbl[k].iss;  IssueReg  = tbl[k].ir;
            ra_a       = {tbl[k].ra1, tbl[k].ra0};
            ra_b       = {tbl[k].ra1, tbl[k].ra0, tbl[k].ra1, tbl[k].ra0};
            #1;
            chk($sformatf("vec%0d rd0", k), 64'(rd_a[0 +: DW]), 64'(tbl[k].e0));
            chk($sformatf("vec%0d rd1", k), 64'(rd_a[DW +: DW]), 64'(tbl[k].e1));
            chk($sformatf("vec%0d rbusy", k), 64'(rb_a), 64'(tbl[k].erb));
            chk($sformatf("vec%0d numbusy", k), 64'(nb_a), 64'(tbl[k].enb));
            check_model();
            edge_update();
        end

        // No-bypass instance: same-cycle read sees old value, next cycle the new one.
        reset_n = 1'b1;
        idle();
        RegWrite0 = 1'b1; WriteReg0 = 5'd12; WriteData0 = 32'h55;
        ra_a = {5'd12, 5'd12};
        ra_b = {5'd12, 5'd12, 5'd12, 5'd12};
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("nobyp same rd%0d", i), 64'(rd_b[i*DW +: DW]), 64'h0);
        chk("byp same rd0", 64'(rd_a[0 +: DW]), 64'h55);
        check_model();
        edge_update();
        idle();
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("nobyp next rd%0d", i), 64'(rd_b[i*DW +: DW]), 64'h55);
        check_model();
        edge_update();

        // Issue every register: count saturates at DEPTH-1 with the zero reg, DEPTH without.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            Issue = 1'b1; IssueReg = AW'(i);
            ra_a = {AW'(i), 5'd0};
            ra_b = {AW'(i), 5'd0, AW'(i), 5'd31};
            #1;
            check_model();
            edge_update();
        end
        idle();
        #1;
        chk("all busy A numbusy", 64'(nb_a), 64'(DEPTH - 1));
        chk("all busy B numbusy", 64'(nb_b), 64'(DEPTH));
        check_model();
        edge_update();

        // Randomized traffic with occasional resets, biased toward low addresses.
        for (int n = 0; n < 400; n++) begin
            reset_n    = ($urandom_range(0, 39) != 0);
            RegWrite0  = 1'($urandom_range(0, 1));
            RegWrite1  = 1'($urandom_range(0, 1));
            WriteReg0  = rand_addr();
            WriteReg1  = rand_addr();
            WriteData0 = $urandom();
            WriteData1 = $urandom();
            Issue      = ($urandom_range(0, 2) != 0);
            IssueReg   = rand_addr();
            ra_a       = {rand_addr(), rand_addr()};
            ra_b       = {rand_addr(), rand_addr(), rand_addr(), rand_addr()};
            #1;
            check_model();
            edge_update();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
